// File: rtl/seven_seg_scanner.sv
// Four-digit display scanner feeding a shared seven_seg_decoder, with
// frame-synchronous double buffering and leading-zero blanking; `SEG_BLINK_EN adds per-digit blinking.
module seven_seg_scanner #(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLINK_FRAMES = 128
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic [19:0] codes_in,
  input  logic        load,
  input  logic        lzb,
  input  logic [3:0]  blink_mask,
  output logic [4:0]  digit,
  output logic [3:0]  an,
  output logic        frame_start,
  output logic        upd_pending
);

  localparam int unsigned      CNT_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [4:0]       BLANK   = 5'd18;
  localparam logic [4:0]       MAX_OK  = 5'd18;

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_sel;
  logic [1:0]       r_sel_d;
  logic             r_sel_d_vld;
  logic             r_frame_start;
  logic             r_upd;
  logic [3:0][4:0]  r_active;
  logic [3:0][4:0]  r_pending;
  logic [4:0]       r_digit;
  logic [3:0]       r_an;

  logic             w_tick;
  logic             w_frame;
  logic             w_hidden;
  logic [3:0]       w_zero;
  logic [3:0]       w_lz_blank;
  logic [4:0]       w_code;

  assign w_tick  = (r_cnt == CNT_MAX);
  assign w_frame = w_tick && (r_sel == 2'd3);

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_sel <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
      r_sel <= r_sel + 2'd1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_frame;
    end
  end

  // Commit reads the old pending value, so a load on the commit cycle stays pending.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_active  <= {4{BLANK}};
      r_pending <= {4{BLANK}};
      r_upd     <= 1'b0;
    end else begin
      if (w_frame && r_upd) begin
        r_active <= r_pending;
      end
      if (load) begin
        r_pending <= codes_in;
        r_upd     <= 1'b1;
      end else if (w_frame) begin
        r_upd <= 1'b0;
      end
    end
  end

`ifdef SEG_BLINK_EN
  localparam int unsigned       FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FCNT_W-1:0] FCNT_MAX = FCNT_W'(BLINK_FRAMES - 1);

  logic [FCNT_W-1:0] r_fcnt;
  logic              r_hidden;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_fcnt   <= '0;
      r_hidden <= 1'b0;
    end else if (r_frame_start) begin
      if (r_fcnt == FCNT_MAX) begin
        r_fcnt   <= '0;
        r_hidden <= ~r_hidden;
      end else begin
        r_fcnt <= r_fcnt + 1'b1;
      end
    end
  end

  assign w_hidden = r_hidden;
`else
  logic w_unused_blink;
  assign w_unused_blink = ^blink_mask ^ (BLINK_FRAMES == 0);
  assign w_hidden       = 1'b0;
`endif

  // A digit is a leading zero when it and every digit to its left hold code 0.
  always_comb begin
    w_zero        = '0;
    w_lz_blank    = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      w_zero[i] = (r_active[i] == 5'd0);
    end
    w_lz_blank[3] = w_zero[3];
    w_lz_blank[2] = w_zero[3] & w_zero[2];
    w_lz_blank[1] = w_zero[3] & w_zero[2] & w_zero[1];
    w_lz_blank[0] = 1'b0;
  end

  always_comb begin
    w_code = r_active[r_sel];
    if (w_code > MAX_OK) begin
      w_code = BLANK;
    end
    if (lzb && w_lz_blank[r_sel]) begin
      w_code = BLANK;
    end
    if (w_hidden && blink_mask[r_sel]) begin
      w_code = BLANK;
    end
  end

  // Anodes run one cycle behind digit to match the decoder's output register.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_digit     <= BLANK;
      r_sel_d     <= '0;
      r_sel_d_vld <= 1'b0;
      r_an        <= 4'b1111;
    end else begin
      r_digit     <= w_code;
      r_sel_d     <= r_sel;
      r_sel_d_vld <= 1'b1;
      r_an        <= r_sel_d_vld ? ~(4'b0001 << r_sel_d) : 4'b1111;
    end
  end

  assign digit       = r_digit;
  assign an          = r_an;
  assign frame_start = r_frame_start;
  assign upd_pending = r_upd;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Randomized self-checking bench for seven_seg_scanner; expectations derive from edge count since reset.
module tb_seven_seg_scanner;

  localparam int unsigned DIV   = 4;
  localparam int unsigned BF    = 2;
  localparam int unsigned FRAME = 4 * DIV;
`ifdef SEG_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        reset  = 1'b0;
  logic [19:0] codes_in = '0;
  logic        load = 1'b0;
  logic        lzb = 1'b0;
  logic [3:0]  blink_mask = '0;
  logic [4:0]  digit;
  logic [3:0]  an;
  logic        frame_start;
  logic        upd_pending;

  seven_seg_scanner #(.REFRESH_DIV(DIV), .BLINK_FRAMES(BF)) dut (
    .clk_in(clk_in), .reset(reset), .codes_in(codes_in), .load(load), .lzb(lzb),
    .blink_mask(blink_mask), .digit(digit), .an(an), .frame_start(frame_start),
    .upd_pending(upd_pending)
  );

  always #5 clk_in = ~clk_in;

  int          checks = 0;
  int          errors = 0;
  int unsigned k;
  logic [4:0]  m_act [4];
  logic [4:0]  m_pend [4];
  bit          m_upd;

  logic [4:0]  ed;
  logic [3:0]  ea;
  logic        efs;
  logic        eupd;

  function automatic logic [19:0] pack(input int d3, input int d2, input int d1, input int d0);
    return {5'(d3), 5'(d2), 5'(d1), 5'(d0)};
  endfunction

  // Hidden phase before edge e: frame_start pulses consumed so far, grouped by BF.
  function automatic bit hidden_at(input int unsigned e);
    if (e < 2) return 1'b0;
    return (((e - 2) / FRAME) / BF) % 2 == 1;
  endfunction

  function automatic logic [4:0] exp_code(input int unsigned slot, input bit hid);
    logic [4:0] c;
    bit lead;
    c = m_act[slot];
    lead = 1'b1;
    for (int j = 3; j >= int'(slot); j--) if (m_act[j] != 0) lead = 1'b0;
    if (c > 18) c = 5'd18;
    if (lzb && slot != 0 && lead) c = 5'd18;
    if (BLINK && hid && blink_mask[slot]) c = 5'd18;
    return c;
  endfunction

  task automatic model_reset();
    k = 0;
    m_upd = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_act[i]  = 5'd18;
      m_pend[i] = 5'd18;
    end
  endtask

  // Advance one clock edge and produce the outputs expected just after it.
  task automatic tick_model(output logic [4:0] o_d, output logic [3:0] o_a,
                            output logic o_fs, output logic o_upd);
    int unsigned e;
    int unsigned sel_pre;
    @(posedge clk_in);
    e = k + 1;
    sel_pre = ((e - 1) / DIV) % 4;
    o_d = exp_code(sel_pre, hidden_at(e));
    o_fs = (e % FRAME) == 0;
    if (e >= 2) o_a = ~(4'b0001 << (((e - 2) / DIV) % 4));
    else o_a = 4'b1111;
    if (o_fs && m_upd) begin
      for (int i = 0; i < 4; i++) m_act[i] = m_pend[i];
      m_upd = 1'b0;
    end
    if (load) begin
      for (int i = 0; i < 4; i++) m_pend[i] = codes_in[i*5 +: 5];
      m_upd = 1'b1;
    end
    o_upd = m_upd;
    k = e;
    #1;
  endtask

  task automatic advance_to_frame();
    while (k % FRAME != 0) tick_model(ed, ea, efs, eupd);
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #2;
    checks++; if (digit !== 5'd18) begin errors++; $display("FAIL reset_digit got %0d want 18", digit); end
    checks++; if (an !== 4'b1111) begin errors++; $display("FAIL reset_an got %b want 1111", an); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs got %b want 0", frame_start); end
    checks++; if (upd_pending !== 1'b0) begin errors++; $display("FAIL reset_upd got %b want 0", upd_pending); end
    @(posedge clk_in);
    @(posedge clk_in);
    #1 reset = 1'b0;
    model_reset();
    for (int n = 0; n < 2 * FRAME; n++) begin
      tick_model(ed, ea, efs, eupd);
      checks++; if (digit !== ed) begin errors++; $display("FAIL idle_digit k=%0d got %0d want %0d", k, digit, ed); end
      checks++; if (an !== ea) begin errors++; $display("FAIL idle_an k=%0d got %b want %b", k, an, ea); end
      checks++; if (frame_start !== efs) begin errors++; $display("FAIL idle_fs k=%0d got %b want %b", k, frame_start, efs); end
    end
  endtask

  task automatic test_scan_basic();
    advance_to_frame();
    codes_in = pack(3, 2, 1, 0);
    load = 1'b1;
    for (int n = 0; n < 3 * FRAME; n++) begin
      tick_model(ed, ea, efs, eupd);
      load = 1'b0;
      checks++; if (digit !== ed) begin errors++; $display("FAIL scan_digit k=%0d got %0d want %0d", k, digit, ed); end
      checks++; if (an !== ea) begin errors++; $display("FAIL scan_an k=%0d got %b want %b", k, an, ea); end
      checks++; if (frame_start !== efs) begin errors++; $display("FAIL scan_fs k=%0d got %b want %b", k, frame_start, efs); end
      checks++; if (upd_pending !== eupd) begin errors++; $display("FAIL scan_upd k=%0d got %b want %b", k, upd_pending, eupd); end
    end
  endtask

  task automatic test_double_load();
    advance_to_frame();
    for (int n = 0; n < 4 * FRAME; n++) begin
      if (n == 1) begin codes_in = pack(5, 5, 5, 5); load = 1'b1; end
      if (n == 4) begin codes_in = pack(9, 8, 7, 6); load = 1'b1; end
      tick_model(ed, ea, efs, eupd);
      load = 1'b0;
      checks++; if (digit === 5'd5) begin errors++; $display("FAIL dbl_stale k=%0d got %0d want not 5", k, digit); end
      checks++; if (digit !== ed) begin errors++; $display("FAIL dbl_digit k=%0d got %0d want %0d", k, digit, ed); end
      checks++; if (frame_start !== efs) begin errors++; $display("FAIL dbl_fs k=%0d got %b want %b", k, frame_start, efs); end
      checks++; if (upd_pending !== eupd) begin errors++; $display("FAIL dbl_upd k=%0d got %b want %b", k, upd_pending, eupd); end
    end
  endtask

  task automatic test_lzb();
    advance_to_frame();
    codes_in = pack(0, 0, 4, 0);
    load = 1'b1;
    for (int n = 0; n < 5 * FRAME; n++) begin
      lzb = (n < 3 * FRAME);
      tick_model(ed, ea, efs, eupd);
      load = 1'b0;
      checks++; if (digit !== ed) begin errors++; $display("FAIL lzb_digit k=%0d lzb=%b got %0d want %0d", k, lzb, digit, ed); end
      checks++; if (an !== ea) begin errors++; $display("FAIL lzb_an k=%0d got %b want %b", k, an, ea); end
    end
    lzb = 1'b0;
  endtask

  task automatic test_invalid_and_coincident();
    advance_to_frame();
    codes_in = pack(1, 2, 25, 7);
    load = 1'b1;
    tick_model(ed, ea, efs, eupd);
    load = 1'b0;
    while ((k + 1) % FRAME != 0) tick_model(ed, ea, efs, eupd);
    codes_in = pack(6, 31, 19, 3);
    load = 1'b1;
    tick_model(ed, ea, efs, eupd);
    load = 1'b0;
    checks++; if (upd_pending !== 1'b1) begin errors++; $display("FAIL coinc_upd got %b want 1", upd_pending); end
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL coinc_fs got %b want 1", frame_start); end
    for (int n = 0; n < 2 * FRAME; n++) begin
      tick_model(ed, ea, efs, eupd);
      checks++; if (digit !== ed) begin errors++; $display("FAIL inv_digit k=%0d got %0d want %0d", k, digit, ed); end
      checks++; if (upd_pending !== eupd) begin errors++; $display("FAIL inv_upd k=%0d got %b want %b", k, upd_pending, eupd); end
    end
  endtask

  task automatic test_blink();
    advance_to_frame();
    codes_in = pack(1, 2, 3, 4);
    load = 1'b1;
    blink_mask = 4'b0001;
    for (int n = 0; n < 10 * FRAME; n++) begin
      tick_model(ed, ea, efs, eupd);
      load = 1'b0;
      checks++; if (digit !== ed) begin errors++; $display("FAIL blink_digit k=%0d got %0d want %0d", k, digit, ed); end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        for (int i = 0; i < 4; i++)
          codes_in[i*5 +: 5] = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
        load = 1'b1;
      end
      lzb = 1'($urandom_range(0, 1));
      if (n % 50 == 0) blink_mask = 4'($urandom_range(0, 15));
      tick_model(ed, ea, efs, eupd);
      load = 1'b0;
      checks++; if (digit !== ed) begin errors++; $display("FAIL rnd_digit k=%0d got %0d want %0d", k, digit, ed); end
      checks++; if (an !== ea) begin errors++; $display("FAIL rnd_an k=%0d got %b want %b", k, an, ea); end
      checks++; if (frame_start !== efs) begin errors++; $display("FAIL rnd_fs k=%0d got %b want %b", k, frame_start, efs); end
      checks++; if (upd_pending !== eupd) begin errors++; $display("FAIL rnd_upd k=%0d got %b want %b", k, upd_pending, eupd); end
    end
  endtask

  task automatic test_mid_reset();
    blink_mask = 4'b0000;
    lzb = 1'b0;
    while (!(((k / DIV) % 4 == 2) && (k % DIV == 1))) tick_model(ed, ea, efs, eupd);
    codes_in = pack(7, 7, 7, 7);
    load = 1'b1;
    tick_model(ed, ea, efs, eupd);
    load = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++; if (digit !== 5'd18) begin errors++; $display("FAIL mrst_digit got %0d want 18", digit); end
    checks++; if (an !== 4'b1111) begin errors++; $display("FAIL mrst_an got %b want 1111", an); end
    checks++; if (upd_pending !== 1'b0) begin errors++; $display("FAIL mrst_upd got %b want 0", upd_pending); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL mrst_fs got %b want 0", frame_start); end
    @(posedge clk_in);
    #1 reset = 1'b0;
    model_reset();
    for (int n = 0; n < 2 * FRAME; n++) begin
      tick_model(ed, ea, efs, eupd);
      checks++; if (an !== ea) begin errors++; $display("FAIL mrst_an_seq k=%0d got %b want %b", k, an, ea); end
      checks++; if (digit !== ed) begin errors++; $display("FAIL mrst_digit_seq k=%0d got %0d want %0d", k, digit, ed); end
      checks++; if (frame_start !== efs) begin errors++; $display("FAIL mrst_fs_seq k=%0d got %b want %b", k, frame_start, efs); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_scan_basic();
    test_double_load();
    test_lzb();
    test_invalid_and_coincident();
    test_blink();
    test_random();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
